fir_out_stream: RTL

// Downstream stage of the folded 37-tap FIR. Captures each FIR result, rounds and saturates it

---
 rtl/fir_out_stream.sv | 111 +++++++++++
 1 files changed

// File: rtl/fir_out_stream.sv
// Purpose : round/saturate FIR MAC results to OUT_WL and stream them out of a small FIFO with TLAST framing.
// Latency : 1 cycle from in_valid to m_tvalid when the FIFO is empty (no bypass path).
// Backpr. : never stalls the FIR; a sample arriving while full with no pop is dropped and flagged on ovf.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   in_data/in_valid  FIR result and its 1-cycle strobe
//   m_tdata/m_tvalid/m_tready/m_tlast  AXI-Stream style master, head of FIFO
//   level             FIFO occupancy 0..DEPTH
//   ovf, sat          sticky drop / clip flags, cleared by flag_clr (a new event in the clear cycle wins)
module fir_out_stream #(
  parameter int IN_WL     = 20,
  parameter int OUT_WL    = 16,
  parameter int SHIFT     = 4,   // >= 1, and IN_WL-SHIFT >= OUT_WL
  parameter int DEPTH     = 8,   // power of 2, >= 2
  parameter int FRAME_LEN = 64,  // >= 1
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_WL-1:0]  in_data,
  input  logic              in_valid,
  output logic [OUT_WL-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [LVL_W-1:0]  level,
  output logic              ovf,
  output logic              sat,
  input  logic              flag_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FCN_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // One extra bit of headroom so the rounding constant can never wrap the sum.
  localparam logic [IN_WL:0] RND = (IN_WL + 1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_WL:0] Q_MAX = {{(IN_WL - OUT_WL + 2){1'b0}}, {(OUT_WL - 1){1'b1}}};
  localparam logic signed [IN_WL:0] Q_MIN = ~Q_MAX;  // -Q_MAX-1 in two's complement

  // ---------------- quantiser ----------------
  logic signed [IN_WL:0] rnd_sum;
  logic signed [IN_WL:0] q_full;
  logic                  clip_hi;
  logic                  clip_lo;
  logic [OUT_WL-1:0]     q_word;

  always_comb begin
    rnd_sum = {in_data[IN_WL-1], in_data} + RND;
    q_full  = rnd_sum >>> SHIFT;  // floor after +half => round half toward +inf
    clip_hi = (q_full > Q_MAX);
    clip_lo = (q_full < Q_MIN);
    if (clip_hi) begin
      q_word = Q_MAX[OUT_WL-1:0];
    end else if (clip_lo) begin
      q_word = Q_MIN[OUT_WL-1:0];
    end else begin
      q_word = q_full[OUT_WL-1:0];
    end
  end

  // ---------------- FIFO ----------------
  logic [OUT_WL-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCN_W-1:0]  fcnt;
  logic              full;
  logic              push;
  logic              pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign m_tvalid = (level != '0);
  assign pop      = m_tvalid & m_tready;
  // A pop in the same cycle frees the slot the incoming word needs, so full+pop still accepts.
  assign push     = in_valid & (~full | pop);
  assign m_tdata  = mem[rd_ptr];
  assign m_tlast  = m_tvalid & (fcnt == FCN_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      // Storage is cleared too so m_tdata reads 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      fcnt   <= '0;
      ovf    <= 1'b0;
      sat    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= q_word;
        wr_ptr      <= wr_ptr + 1'b1;  // DEPTH is a power of 2, wrap is natural
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        fcnt   <= (fcnt == FCN_W'(FRAME_LEN - 1)) ? '0 : fcnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Set beats clear so an event in the clear cycle is not lost.
      ovf <= (in_valid & full & ~pop) | (ovf & ~flag_clr);
      sat <= (push & (clip_hi | clip_lo)) | (sat & ~flag_clr);
    end
  end

endmodule
